display_scan_scheduler: RTL

DISPLAY_SCAN_SCHEDULER -- requirements
Module: display_scan_scheduler

---
 rtl/display_scan_scheduler_if.sv | 37 +++
 rtl/display_scan_scheduler.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/display_scan_scheduler_if.sv
// display_scan_scheduler_if
// Bundles the scan scheduler's load handshake, scan tick and display outputs.
//   master : drives t_1k, bcd_in, load, lz_en; observes the display outputs.
//   slave  : the scheduler; consumes the requests and drives the display side.
// Signals:
//   t_1k        scan tick, one clk wide
//   bcd_in      BCD value to display, digit 0 (units) in bits [3:0]
//   load        load request, held high until load_ack
//   load_ack    one-cycle pulse: bcd_in captured
//   lz_en       leading-zero suppression enable
//   an_en       one-hot digit enable, active-high, bit 0 = units
//   digit_bcd   BCD code of the currently selected digit
//   frame_start one-cycle pulse when the scan wraps to digit 0
//   bcd_err     sticky flag: a non-BCD nibble reached the display register
interface display_scan_scheduler_if #(
  parameter int N_DIGITS = 4
);
  logic                  t_1k;
  logic [4*N_DIGITS-1:0] bcd_in;
  logic                  load;
  logic                  load_ack;
  logic                  lz_en;
  logic [N_DIGITS-1:0]   an_en;
  logic [3:0]            digit_bcd;
  logic                  frame_start;
  logic                  bcd_err;

  modport master (
    output t_1k, bcd_in, load, lz_en,
    input  load_ack, an_en, digit_bcd, frame_start, bcd_err
  );

  modport slave (
    input  t_1k, bcd_in, load, lz_en,
    output load_ack, an_en, digit_bcd, frame_start, bcd_err
  );
endinterface

// File: rtl/display_scan_scheduler.sv
// display_scan_scheduler
// Time-multiplexes N_DIGITS 7-segment digits. Each t_1k tick moves the scan to
// the next digit with BLANK_CYCLES clocks of all-off blanking in between. New
// values arrive through a pending register and are promoted to the display
// register only when the scan wraps to digit 0, so a frame never mixes values.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  display_scan_scheduler_if.slave (see the interface for signal list)
module display_scan_scheduler #(
  parameter int N_DIGITS     = 4,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  display_scan_scheduler_if.slave bus
);

  localparam int                  IDX_W      = $clog2(N_DIGITS);
  localparam int                  DW         = 4 * N_DIGITS;
  localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(N_DIGITS - 1);
  localparam logic [IDX_W-1:0]    IDX_ZERO   = {IDX_W{1'b0}};
  localparam logic [7:0]          BLANK_LOAD = (BLANK_CYCLES > 0) ? 8'(BLANK_CYCLES - 1) : 8'd0;
  localparam logic [N_DIGITS-1:0] ONE_HOT0   = {{(N_DIGITS-1){1'b0}}, 1'b1};
  localparam logic [N_DIGITS-1:0] AN_OFF     = {N_DIGITS{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DW-1:0]       disp_q;
  logic [DW-1:0]       pend_q;
  logic                pend_valid_q;
  logic [7:0]          cnt_q;
  logic [N_DIGITS-1:0] an_en_q;
  logic [3:0]          digit_bcd_q;
  logic                load_ack_q;
  logic                frame_start_q;
  logic                bcd_err_q;

  logic [IDX_W-1:0]    idx_next_s;
  logic                wrap_s;
  logic                xfer_s;
  logic                capture_s;
  logic [DW-1:0]       disp_d;
  logic [DW-1:0]       pend_d;
  logic                pend_valid_d;
  logic [N_DIGITS-1:0] mask_s;

  // Selects one BCD nibble out of a packed multi-digit value.
  function automatic logic [3:0] nibble(input logic [DW-1:0] v, input logic [IDX_W-1:0] i);
    return v[{i, 2'b00} +: 4];
  endfunction

  // True when any nibble of the value is outside 0..9.
  function automatic logic bcd_invalid(input logic [DW-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (v[4*k +: 4] > 4'd9) bad = 1'b1;
      else                    bad = bad;
    end
    return bad;
  endfunction

  // Per-digit enable mask. Walking from the top digit down, zero_run stays
  // set while every digit seen so far is 0; those digits are leading zeros.
  // Digit 0 is never suppressed, non-BCD digits are always blanked.
  function automatic logic [N_DIGITS-1:0] digit_mask(input logic [DW-1:0] v, input logic lz);
    logic [N_DIGITS-1:0] m;
    logic                zero_run;
    m        = {N_DIGITS{1'b0}};
    zero_run = 1'b1;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run & (v[4*k +: 4] == 4'd0);
      m[k]     = (v[4*k +: 4] <= 4'd9) & ~(lz & zero_run & (k != 0));
    end
    return m;
  endfunction

  // Next scan index, frame-boundary detection and double-buffer bookkeeping.
  // A capture only happens into an empty pending slot, so a request that
  // meets a full slot waits and is taken the cycle after the boundary drain.
  always_comb begin
    idx_next_s = (idx_q == LAST_IDX) ? IDX_ZERO : idx_q + 1'b1;

    wrap_s = 1'b0;
    if (bus.t_1k && (state_q == ST_IDLE)) begin
      wrap_s = 1'b1;
    end else if (bus.t_1k && (state_q == ST_SHOW) && (idx_q == LAST_IDX)) begin
      wrap_s = 1'b1;
    end else begin
      wrap_s = 1'b0;
    end

    xfer_s    = wrap_s & pend_valid_q;
    capture_s = bus.load & ~pend_valid_q;
    disp_d    = xfer_s ? pend_q : disp_q;

    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    if (capture_s) begin
      pend_d       = bus.bcd_in;
      pend_valid_d = 1'b1;
    end else if (xfer_s) begin
      pend_d       = pend_q;
      pend_valid_d = 1'b0;
    end else begin
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;
    end

    // lz_en is sampled here only when a SHOW slot is entered below.
    mask_s = digit_mask(disp_d, bus.lz_en);
  end

  // Scan FSM together with the display/pending registers and all outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= IDX_ZERO;
      disp_q        <= {DW{1'b0}};
      pend_q        <= {DW{1'b0}};
      pend_valid_q  <= 1'b0;
      cnt_q         <= 8'd0;
      an_en_q       <= AN_OFF;
      digit_bcd_q   <= 4'd0;
      load_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
      bcd_err_q     <= 1'b0;
    end else begin
      disp_q        <= disp_d;
      pend_q        <= pend_d;
      pend_valid_q  <= pend_valid_d;
      load_ack_q    <= capture_s;
      frame_start_q <= wrap_s;
      bcd_err_q     <= bcd_err_q | bcd_invalid(disp_d);

      case (state_q)
        ST_IDLE: begin
          if (bus.t_1k) begin
            state_q     <= ST_SHOW;
            idx_q       <= IDX_ZERO;
            an_en_q     <= ONE_HOT0 & mask_s;
            digit_bcd_q <= nibble(disp_d, IDX_ZERO);
          end else begin
            an_en_q <= AN_OFF;
          end
        end

        ST_SHOW: begin
          if (bus.t_1k) begin
            idx_q       <= idx_next_s;
            digit_bcd_q <= nibble(disp_d, idx_next_s);
            if (BLANK_CYCLES == 0) begin
              state_q <= ST_SHOW;
              an_en_q <= (ONE_HOT0 << idx_next_s) & mask_s;
            end else begin
              state_q <= ST_BLANK;
              an_en_q <= AN_OFF;
              cnt_q   <= BLANK_LOAD;
            end
          end else begin
            state_q <= ST_SHOW;
          end
        end

        // t_1k is deliberately ignored while blanking.
        ST_BLANK: begin
          if (cnt_q == 8'd0) begin
            state_q <= ST_SHOW;
            an_en_q <= (ONE_HOT0 << idx_q) & mask_s;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          an_en_q <= AN_OFF;
        end
      endcase
    end
  end

  assign bus.an_en       = an_en_q;
  assign bus.digit_bcd   = digit_bcd_q;
  assign bus.load_ack    = load_ack_q;
  assign bus.frame_start = frame_start_q;
  assign bus.bcd_err     = bcd_err_q;

endmodule
